// File: rtl/i2s_encoder.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : i2s_encoder
// Description : Philips I2S transmitter (bus master). Generates sck/ws from
//               clk_60MHz and serialises one stereo pair per frame, MSB
//               first, from a one-deep valid/ready holding register.
//               Optional macro I2S_TX_UNDERRUN_CNT_EN adds a saturating
//               16-bit underrun counter output (underrun_cnt).
// Revision    : 1.0 - initial release
//============================================================================
module i2s_encoder #(
  parameter int DATAWIDTH = 24,
  parameter int SLOTWIDTH = 32,
  parameter int CLKDIV    = 10
) (
  input  logic                 clk_60MHz,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DATAWIDTH-1:0] l_data,
  input  logic [DATAWIDTH-1:0] r_data,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 sck,
  output logic                 ws,
  output logic                 sd,
  output logic                 frame_start,
  output logic                 underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]          underrun_cnt
`endif
);

  localparam int c_FRAME_BITS = 2 * SLOTWIDTH;
  localparam int c_BIT_W      = $clog2(c_FRAME_BITS);
  localparam int c_DIV_W      = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int c_PAD_W      = SLOTWIDTH - DATAWIDTH;

  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(c_FRAME_BITS - 1);
  localparam logic [c_BIT_W-1:0] c_WS_FIRST = c_BIT_W'(SLOTWIDTH - 1);
  localparam logic [c_BIT_W-1:0] c_WS_LAST  = c_BIT_W'(c_FRAME_BITS - 2);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLKDIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_DIV_W-1:0]      r_div_cnt;
  logic                    r_sck;
  logic                    r_ws;
  logic [c_BIT_W-1:0]      r_bit_cnt;
  logic [c_FRAME_BITS-1:0] r_shift;
  logic                    r_frame_start;
  logic                    r_underrun;
  logic                    r_hold_full;
  logic [DATAWIDTH-1:0]    r_l_hold;
  logic [DATAWIDTH-1:0]    r_r_hold;

  logic                    w_running;
  logic                    w_div_wrap;
  logic                    w_tick;
  logic                    w_frame_end;
  logic                    w_stop;
  logic                    w_load;
  logic                    w_accept;
  logic [c_BIT_W-1:0]      w_bit_nxt;
  logic                    w_ws_nxt;
  logic [SLOTWIDTH-1:0]    w_l_slot;
  logic [SLOTWIDTH-1:0]    w_r_slot;

  // A tick is the cycle in which sck falls; all bit-level state moves then.
  assign w_running   = (r_state != S_IDLE);
  assign w_div_wrap  = w_running && (r_div_cnt == c_DIV_LAST);
  assign w_tick      = w_div_wrap && r_sck;
  assign w_frame_end = w_tick && (r_bit_cnt == c_LAST_BIT);
  // Draining with en still low: finish here instead of loading a new frame.
  assign w_stop      = w_frame_end && (r_state == S_DRAIN) && !en;
  assign w_load      = w_frame_end && !w_stop;
  assign w_accept    = data_valid && !r_hold_full;

  assign w_bit_nxt = (r_bit_cnt == c_LAST_BIT) ? '0 : (r_bit_cnt + c_BIT_W'(1));
  // ws leads the slot boundary by one bit (Philips format).
  assign w_ws_nxt  = (w_bit_nxt >= c_WS_FIRST) && (w_bit_nxt <= c_WS_LAST);

  // Left-justify each sample in its slot; low pad bits are zero.
  assign w_l_slot = SLOTWIDTH'(r_l_hold) << c_PAD_W;
  assign w_r_slot = SLOTWIDTH'(r_r_hold) << c_PAD_W;

  // State register.
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: a drain always completes the frame in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en) w_state_nxt = S_RUN;
      S_RUN:   if (!en) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (en) begin
          w_state_nxt = S_RUN;
        end else if (w_frame_end) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit-clock divider, bit counter, word select and serialiser.
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt     <= '0;
      r_sck         <= 1'b0;
      r_ws          <= 1'b0;
      r_bit_cnt     <= c_LAST_BIT;
      r_shift       <= '0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= w_load;
      r_underrun    <= w_load && !r_hold_full;
      if (!w_running) begin
        r_div_cnt <= '0;
        r_sck     <= 1'b0;
        r_ws      <= 1'b0;
        r_bit_cnt <= c_LAST_BIT;
        r_shift   <= '0;
      end else begin
        r_div_cnt <= w_div_wrap ? '0 : (r_div_cnt + c_DIV_W'(1));
        if (w_div_wrap) begin
          r_sck <= !r_sck;
        end
        if (w_tick) begin
          if (w_stop) begin
            r_bit_cnt <= c_LAST_BIT;
            r_ws      <= 1'b0;
            r_shift   <= '0;
          end else begin
            r_bit_cnt <= w_bit_nxt;
            r_ws      <= w_ws_nxt;
            if (w_load) begin
              // Empty holding register at a load sends silence.
              r_shift <= r_hold_full ? {w_l_slot, w_r_slot} : '0;
            end else begin
              r_shift <= r_shift << 1;
            end
          end
        end
      end
    end
  end

  // One-deep holding register; a load frees it, an accept fills it.
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_full <= 1'b0;
      r_l_hold    <= '0;
      r_r_hold    <= '0;
    end else begin
      if (w_load) begin
        r_hold_full <= w_accept;
      end else if (w_accept) begin
        r_hold_full <= 1'b1;
      end
      if (w_accept) begin
        r_l_hold <= l_data;
        r_r_hold <= r_data;
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic        r_en_d;
  logic [15:0] r_underrun_cnt;

  // Saturating underrun count, restarted whenever the encoder is enabled.
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_en_d         <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      r_en_d <= en;
      if (en && !r_en_d) begin
        r_underrun_cnt <= '0;
      end else if (r_underrun && (r_underrun_cnt != 16'hFFFF)) begin
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
      end
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`endif

  assign data_ready  = !r_hold_full;
  assign sck         = r_sck;
  assign ws          = r_ws;
  assign sd          = r_shift[c_FRAME_BITS-1];
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_encoder.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : tb_i2s_encoder
// Description : Directed self-checking bench for i2s_encoder with
//               CLKDIV=2, DATAWIDTH=24, SLOTWIDTH=32.
// Revision    : 1.0 - initial release
//============================================================================
module tb_i2s_encoder;

  logic        clk_60MHz;
  logic        rst_n;
  logic        en;
  logic [23:0] l_data;
  logic [23:0] r_data;
  logic        data_valid;
  wire logic   data_ready;
  wire logic   sck;
  wire logic   ws;
  wire logic   sd;
  wire logic   frame_start;
  wire logic   underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  wire logic [15:0] underrun_cnt;
`endif

  i2s_encoder #(
    .DATAWIDTH(24),
    .SLOTWIDTH(32),
    .CLKDIV   (2)
  ) dut (
    .clk_60MHz  (clk_60MHz),
    .rst_n      (rst_n),
    .en         (en),
    .l_data     (l_data),
    .r_data     (r_data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .sck        (sck),
    .ws         (ws),
    .sd         (sd),
    .frame_start(frame_start),
    .underrun   (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  initial clk_60MHz = 1'b0;
  always #5 clk_60MHz = ~clk_60MHz;

  int  tests  = 0;
  int  failed = 0;

  // Receiver-side capture: bits sampled at sck rising, frame/underrun pulses.
  bit  rx_sd[$];
  bit  rx_ws[$];
  time sck_t[$];
  time fs_t[$];
  int  fs_cnt = 0;
  int  ur_cnt = 0;
  int  ur_alone = 0;

  always @(posedge sck) begin
    #1;
    rx_sd.push_back(sd);
    rx_ws.push_back(ws);
    sck_t.push_back($time);
  end

  always @(posedge clk_60MHz) begin
    #1;
    if (frame_start === 1'b1) begin
      fs_cnt++;
      fs_t.push_back($time);
    end
    if (underrun === 1'b1) ur_cnt++;
    if (underrun === 1'b1 && frame_start !== 1'b1) ur_alone++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] word_at(input int s, input bit sel_ws);
    logic [63:0] w;
    w = 'x;
    if (s + 64 <= rx_sd.size()) begin
      for (int i = 0; i < 64; i++) w[63-i] = sel_ws ? rx_ws[s+i] : rx_sd[s+i];
    end
    return w;
  endfunction

  task automatic clear_capture();
    rx_sd.delete();
    rx_ws.delete();
    sck_t.delete();
    fs_t.delete();
    fs_cnt   = 0;
    ur_cnt   = 0;
    ur_alone = 0;
  endtask

  // Bounded wait for the given number of frame_start pulses.
  task automatic wait_fs(input int target, input string tag);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_60MHz);
      if (fs_cnt >= target) break;
    end
    check(tag, 64'(fs_cnt >= target), 64'd1);
  endtask

  function automatic logic [23:0] mkl(input int k);
    return 24'hC00010 + 24'(k);
  endfunction

  function automatic logic [23:0] mkr(input int k);
    return 24'h5A0000 + 24'(k);
  endfunction

  int bp_val;
  bit acc_prev;
  int ready_bad;
  int rises;

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    l_data     = '0;
    r_data     = '0;
    data_valid = 1'b0;
    repeat (3) @(negedge clk_60MHz);

    // Reset values.
    check("rst_sck", 64'(sck), 64'd0);
    check("rst_ws", 64'(ws), 64'd0);
    check("rst_sd", 64'(sd), 64'd0);
    check("rst_ready", 64'(data_ready), 64'd1);
    check("rst_fs", 64'(frame_start), 64'd0);
    check("rst_ur", 64'(underrun), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_60MHz);

    // Single frame, then three underrun frames, then graceful stop at bit 10.
    l_data     = 24'hA5A5A5;
    r_data     = 24'h123456;
    data_valid = 1'b1;
    @(negedge clk_60MHz);
    data_valid = 1'b0;
    check("preload_ready", 64'(data_ready), 64'd0);
    clear_capture();
    en = 1'b1;
    wait_fs(4, "wait_4_frames");
    repeat (41) @(negedge clk_60MHz);
    en = 1'b0;
    repeat (300) @(negedge clk_60MHz);

    check("sck_period", 64'(sck_t[2] - sck_t[1]), 64'd40);
    check("frame_len", 64'(fs_t[1] - fs_t[0]), 64'd2560);
    check("frame0_sd", word_at(1, 1'b0), 64'hA5A5A500_12345600);
    check("frame0_ws", word_at(1, 1'b1), 64'h00000001_FFFFFFFE);
    check("frame3_ws", word_at(193, 1'b1), 64'h00000001_FFFFFFFE);
    check("underrun_sd", word_at(65, 1'b0) | word_at(129, 1'b0) | word_at(193, 1'b0), 64'd0);
    check("underrun_pulses", 64'(ur_cnt), 64'd3);
    check("underrun_coincident", 64'(ur_alone), 64'd0);
    check("stop_fs_count", 64'(fs_cnt), 64'd4);
    check("stop_sck_rises", 64'(rx_sd.size()), 64'd257);
    check("stop_sck", 64'(sck), 64'd0);
    check("stop_ws", 64'(ws), 64'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("underrun_cnt", 64'(underrun_cnt), 64'd3);
`endif

    // Backpressure: valid held high with an incrementing pair.
    bp_val     = 0;
    l_data     = mkl(0);
    r_data     = mkr(0);
    data_valid = 1'b1;
    @(negedge clk_60MHz);
    bp_val = 1;
    l_data = mkl(1);
    r_data = mkr(1);
    check("bp_preload_ready", 64'(data_ready), 64'd0);
    clear_capture();
    acc_prev  = 1'b0;
    ready_bad = 0;
    en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_60MHz);
      if (acc_prev) begin
        bp_val++;
        l_data = mkl(bp_val);
        r_data = mkr(bp_val);
      end
      if (data_ready !== frame_start) ready_bad++;
      acc_prev = data_ready;
      if (fs_cnt >= 4) break;
    end
    check("bp_wait_4_frames", 64'(fs_cnt), 64'd4);
    en = 1'b0;
    @(negedge clk_60MHz);
    data_valid = 1'b0;
    repeat (300) @(negedge clk_60MHz);
    check("bp_ready_pattern", 64'(ready_bad), 64'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_frame%0d", k), word_at(1 + 64 * k, 1'b0), {mkl(k), 8'h00, mkr(k), 8'h00});
    end
    check("bp_no_underrun", 64'(ur_cnt), 64'd0);
    check("bp_fs_count", 64'(fs_cnt), 64'd4);
    check("bp_hold_full", 64'(data_ready), 64'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("bp_underrun_cnt", 64'(underrun_cnt), 64'd0);
`endif

    // Reset mid-RUN, while sck is high and the left MSB is on sd.
    l_data     = mkl(9);
    r_data     = mkr(9);
    data_valid = 1'b1;
    clear_capture();
    en = 1'b1;
    wait_fs(1, "mid_wait_frame");
    repeat (2) @(negedge clk_60MHz);
    check("mid_sck", 64'(sck), 64'd1);
    check("mid_sd", 64'(sd), 64'd1);
    check("mid_ready", 64'(data_ready), 64'd0);
    #2;
    rst_n      = 1'b0;
    data_valid = 1'b0;
    en         = 1'b0;
    #1;
    check("async_sck", 64'(sck), 64'd0);
    check("async_ws", 64'(ws), 64'd0);
    check("async_sd", 64'(sd), 64'd0);
    check("async_ready", 64'(data_ready), 64'd1);
    check("async_fs", 64'(frame_start), 64'd0);
    @(negedge clk_60MHz);
    rst_n = 1'b1;
    rises = rx_sd.size();
    repeat (20) @(negedge clk_60MHz);
    check("post_rst_sck", 64'(sck), 64'd0);
    check("post_rst_rises", 64'(rx_sd.size() - rises), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
